// File: rtl/mult_arbiter.sv
// mult_arbiter: one pipelined signed 8x8 multiplier shared by NUM_REQ requesters.
// Define MULT_ARB_ROUND_ROBIN_EN for round-robin grants; otherwise fixed priority.
module mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 2
) (
  input  logic                   clk100,
  input  logic                   rst_n,
  input  logic                   arb_en,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_a,
  input  logic [NUM_REQ*8-1:0]   req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [15:0]            rsp_prod,
  output logic                   busy
);

  logic [NUM_REQ-1:0] gnt;
  logic               found;
  logic               accept;
  logic [7:0]         a_sel;
  logic [7:0]         b_sel;
  logic [15:0]        mul;

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [NUM_REQ-1:0] tag_q  [LATENCY];
  logic [NUM_REQ-1:0] tag_d  [LATENCY];
  logic [15:0]        prod_q [LATENCY];
  logic [15:0]        prod_d [LATENCY];

`ifdef MULT_ARB_ROUND_ROBIN_EN
  localparam int LW = $clog2(NUM_REQ);

  logic [LW-1:0] last_q, last_d;
  logic [LW-1:0] win;
  int            idx;

  // Search from the requester after the last one accepted, wrapping.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    win   = last_q;
    idx   = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_q) + off) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
        win      = LW'(idx);
      end
    end
  end

  // Pointer moves only when a grant is actually taken.
  always_comb begin
    last_d = accept ? win : last_q;
  end

  // Pointer register; reset gives requester 0 first priority.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) last_q <= LW'(NUM_REQ - 1);
    else        last_q <= last_d;
  end
`else
  // Lowest-index valid requester wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end
`endif

  assign req_ready = arb_en ? gnt : '0;
  assign accept    = |req_ready;

  // Route the winner's operands into the multiplier.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        a_sel = req_a[8*i +: 8];
        b_sel = req_b[8*i +: 8];
      end
    end
  end

  // Sign-extended 16x16 keeps the full signed 8x8 result in the low half.
  assign mul = {{8{a_sel[7]}}, a_sel} * {{8{b_sel[7]}}, b_sel};

  // Stages shift every cycle; data and tag hold when a bubble passes.
  always_comb begin
    vld_d[0]  = accept;
    tag_d[0]  = accept ? req_ready : tag_q[0];
    prod_d[0] = accept ? mul : prod_q[0];
    for (int k = 1; k < LATENCY; k++) begin
      vld_d[k]  = vld_q[k-1];
      tag_d[k]  = vld_q[k-1] ? tag_q[k-1] : tag_q[k];
      prod_d[k] = vld_q[k-1] ? prod_q[k-1] : prod_q[k];
    end
  end

  // Pipeline registers; reset drops everything in flight.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        tag_q[k]  <= '0;
        prod_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < LATENCY; k++) begin
        tag_q[k]  <= tag_d[k];
        prod_q[k] <= prod_d[k];
      end
    end
  end

  assign rsp_valid = vld_q[LATENCY-1] ? tag_q[LATENCY-1] : '0;
  assign rsp_prod  = prod_q[LATENCY-1];
  assign busy      = |vld_q;

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Shares one pipelined signed 8x8 multiplier among `NUM_REQ` requesters on the `clk100` domain. Each requester presents operands with a valid/ready handshake. The arbiter grants at most one requester per cycle and pushes its operands into a fixed-latency multiply pipeline. After exactly `LATENCY` cycles it returns the 16-bit signed product, tagged one-hot back to the originating requester. It sits between the board-independent common logic and any number of consumers that need multiplication, replacing per-consumer multipliers.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `LATENCY`, default 2: multiply pipeline depth in cycles from accept edge to result register; legal range 1..4.

Ports:
- `clk100`  in  1: sole clock; all logic is rising-edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `arb_en`  in  1: grant enable. When low, no new grants are issued, but in-flight operations still complete.
- `req_valid`  in  NUM_REQ: per-requester operand valid.
- `req_a`  in  NUM_REQ*8: packed signed operand A. Requester i occupies bits [8i+7:8i].
- `req_b`  in  NUM_REQ*8: packed signed operand B, same packing as `req_a`.
- `req_ready`  out  NUM_REQ: one-hot or zero grant.
- `rsp_valid`  out  NUM_REQ: one-hot or zero result strobe.
- `rsp_prod`  out  16: signed product for the requester flagged by `rsp_valid`.
- `busy`  out  1: high while any pipeline stage holds a valid operation.

## Operation
- **Arbitration (combinational):**
  - `req_ready[i]` is high only when `arb_en` is high, `req_valid[i]` is high, and i is the arbitration winner.
  - At most one bit of `req_ready` is high. `req_ready` may depend on `req_valid`.
- **Accept:** an operation is accepted at a rising edge where `req_valid[i] & req_ready[i]`. At that edge the arbiter captures `req_a[i]`, `req_b[i]` and the one-hot tag i into pipeline stage 1.
- **Round-robin order:**
  - A registered pointer `last` holds the index of the most recently accepted requester.
  - The search order is `last+1`, `last+2`, … wrapping modulo `NUM_REQ`.
  - `last` updates only on an accept.
  - `last` resets to `NUM_REQ-1`, so requester 0 has first priority after reset.
- **Arithmetic:**
  - `rsp_prod` = `$signed(a) * $signed(b)`, full 16-bit result with no truncation or saturation.
  - The extreme cases are -128*-128 = 16384 (0x4000) and -128*127 = -16256 (0xC080).
- **Pipeline:**
  - The pipeline has `LATENCY` stages. Each stage holds a valid bit, a one-hot tag and the data.
  - Stages shift every cycle unconditionally. There is no response backpressure; requesters must sink `rsp_valid` whenever it fires.
  - The multiply may be placed in any stage, but the output must come from the final stage register.
- **Outputs:**
  - `rsp_valid` equals the final stage's valid bit ANDed with its tag.
  - `rsp_prod` holds the final stage's product when valid; otherwise it holds its last value.
  - `busy` is the OR of all stage valid bits.
- **Boundary conditions:**
  - If all requesters are valid every cycle, the arbiter grants one per cycle in strict rotation, giving 100% multiplier utilisation.
  - A requester that drops `req_valid` without being granted loses nothing; the arbiter keeps no state for it.
  - If `arb_en` falls while requests are pending, no accept occurs. Ops already in the pipeline still deliver.
  - Reset mid-operation clears every stage immediately and asynchronously. In-flight results are discarded and no `rsp_valid` is issued for them.

## Timing
- **Reset values:** `req_ready`=0 (because `arb_en`/valid gating applies), `rsp_valid`=0, `rsp_prod`=0x0000, `busy`=0, `last`=`NUM_REQ-1`, all stage valids 0.
- **Latency:** for an accept at edge E, `rsp_valid[i]` and `rsp_prod` are valid for exactly one cycle, following edge E+`LATENCY`-1. With `LATENCY`=1, the response appears in the cycle right after the accept edge.
- **Throughput:** one accept per cycle, one response per cycle.
- **Ordering:** responses leave in accept order.
- **`busy`:** rises in the cycle after the first accept and falls in the cycle after the last response cycle.

## Configuration
- Macro: `MULT_ARB_ROUND_ROBIN_EN`.
- **Defined:** round-robin arbitration exactly as described above.
- **Undefined:**
  - Fixed priority: the lowest-index valid requester always wins, and the `last` pointer is not implemented.
  - Requester `NUM_REQ-1` can therefore be starved.
- All other behaviour, ports and timing are identical in both builds.

## Test plan
- **Reset:** assert `rst_n`=0 with all `req_valid`=1. Required: all outputs are at reset values. After release with `arb_en`=1, the first grant goes to requester 0.
- **Single op, `LATENCY`=2:** requester 2 sends a=-128, b=-128. Required: `rsp_valid`=4'b0100 with `rsp_prod`=0x4000 for one cycle, two edges after accept. Then a=-128, b=127. Required: `rsp_prod`=0xC080.
- **Saturated load, `NUM_REQ`=4, round-robin build:** hold all four valid for 8 cycles. Required: grant sequence 0,1,2,3,0,1,2,3, with responses in the same order and each product matching its own operands.
- **Fixed-priority build:** same stimulus. Required: all 8 grants go to requester 0 and requesters 1..3 are never ready.
- **Stall:** drop `arb_en` for 3 cycles while the pipeline holds 2 ops. Required: both responses still arrive, there are no accepts during the stall, and `busy` falls after the second response.
- **Mid-flight reset:** pulse `rst_n` low one cycle after accept. Required: no `rsp_valid` ever appears for that op, and `busy`=0 immediately.
